// File: rtl/pattern_pkg.sv
// Shared types and helpers for the pattern serializer.
// SERIAL_PARITY_EN adds a parity bit to every frame.
package pattern_pkg;

  localparam int SER_DEFAULT_WIDTH = 8;

  typedef enum logic {
    SER_IDLE  = 1'b0,
    SER_SHIFT = 1'b1
  } ser_state_t;

  function automatic int ser_frame_len(input int width);
`ifdef SERIAL_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/ser_hold_buf.sv
// Single-entry holding register in front of the serializer shifter.
// Accepts a word only while empty; pop drains it into the shifter.
module ser_hold_buf
  import pattern_pkg::*;
#(
  parameter int WIDTH = SER_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             pop,
  output logic [WIDTH-1:0] hold,
  output logic             hold_full,
  output logic             din_ready
);

  logic accept;

  assign din_ready = !hold_full;
  assign accept    = din_valid && din_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else if (accept) begin
      hold      <= din;
      hold_full <= 1'b1;
    end else if (pop) begin
      hold_full <= 1'b0;
    end
  end

endmodule

// File: rtl/pattern_serializer.sv
// MSB-first parallel-to-serial stage feeding the pattern detector.
// Optional SERIAL_PARITY_EN appends a parity bit to each frame.
module pattern_serializer
  import pattern_pkg::*;
#(
  parameter int WIDTH      = SER_DEFAULT_WIDTH,
  parameter bit IDLE_BIT   = 1'b0,
  parameter int PARITY_ODD = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_done,
  output logic             busy
);

  localparam int FL = ser_frame_len(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(FL - 1);

  if (WIDTH < 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("pattern_serializer: illegal WIDTH or PARITY_ODD");
  end

  ser_state_t      state_q, state_d;
  logic [FL-1:0]   shift_q, shift_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [FL-1:0]   load_val;
  logic [WIDTH-1:0] hold;
  logic            hold_full;
  logic            hold_full_d;
  logic            last;
  logic            pop;
  logic            ser_out_d;
  logic            ser_valid_d;
  logic            frame_done_d;
  logic            busy_d;

  ser_hold_buf #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .pop       (pop),
    .hold      (hold),
    .hold_full (hold_full),
    .din_ready (din_ready)
  );

`ifdef SERIAL_PARITY_EN
  assign load_val = {hold, (^hold) ^ 1'(PARITY_ODD)};
`else
  assign load_val = hold;
`endif

  assign last = (state_q == SER_SHIFT) && (cnt_q == LAST);
  assign pop  = hold_full && ((state_q == SER_IDLE) || last);

  // accept and pop never coincide: accept needs hold_full=0
  assign hold_full_d = (din_valid && din_ready) || (hold_full && !pop);

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    priority case (1'b1)
      pop: begin
        state_d = SER_SHIFT;
        shift_d = load_val;
        cnt_d   = '0;
      end
      last: begin
        state_d = SER_IDLE;
        shift_d = '0;
        cnt_d   = '0;
      end
      (state_q == SER_SHIFT): begin
        shift_d = shift_q << 1;
        cnt_d   = cnt_q + CW'(1);
      end
      default: ;
    endcase
    ser_valid_d  = (state_d == SER_SHIFT);
    ser_out_d    = ser_valid_d ? shift_d[FL-1] : IDLE_BIT;
    frame_done_d = ser_valid_d && (cnt_d == LAST);
    busy_d       = ser_valid_d || hold_full_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SER_IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      ser_out    <= IDLE_BIT;
      ser_valid  <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      ser_out    <= ser_out_d;
      ser_valid  <= ser_valid_d;
      frame_done <= frame_done_d;
      busy       <= busy_d;
    end
  end

endmodule

// File: tb/tb_pattern_serializer.sv
// Directed bench for pattern_serializer with a timeline model.
// Honors SERIAL_PARITY_EN (even parity, PARITY_ODD=0).
module tb_pattern_serializer;

`ifdef SERIAL_PARITY_EN
  localparam int FL = 9;
  localparam logic [31:0] E90   = {8'h90, 1'b0};
  localparam logic [31:0] EA53C = {8'hA5, 1'b0, 8'h3C, 1'b0};
  localparam logic [31:0] EF00F = {8'hF0, 1'b0, 8'h0F, 1'b0};
  localparam logic [31:0] E81   = {8'h81, 1'b0};
  localparam logic [31:0] E07   = {8'h07, 1'b1};
`else
  localparam int FL = 8;
  localparam logic [31:0] E90   = 32'h90;
  localparam logic [31:0] EA53C = 32'hA53C;
  localparam logic [31:0] EF00F = 32'hF00F;
  localparam logic [31:0] E81   = 32'h81;
  localparam logic [31:0] E07   = 32'h07;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       ser_out;
  logic       ser_valid;
  logic       frame_done;
  logic       busy;

  int checks = 0;
  int failures = 0;

  pattern_serializer #(
    .WIDTH(8),
    .IDLE_BIT(1'b0),
    .PARITY_ODD(0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Model: each accepted word owns a window of FL cycles starting at
  // its load edge L = max(accept+1, previous L + FL).
  int         cyc;
  int         nw;
  int         ld [64];
  logic [8:0] fr [64];

  function automatic logic [8:0] frame_of(input logic [7:0] w);
`ifdef SERIAL_PARITY_EN
    return {w, ^w};
`else
    return {1'b0, w};
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0;
      nw  = 0;
    end else begin
      int e;
      int l;
      cyc = cyc + 1;
      e = cyc;
      if (din_valid && (nw == 0 || ld[nw-1] <= e - 1) && nw < 64) begin
        l = e + 1;
        if (nw > 0 && ld[nw-1] + FL > l) l = ld[nw-1] + FL;
        ld[nw] = l;
        fr[nw] = frame_of(din);
        nw = nw + 1;
      end
    end
  end

  always @(negedge clk) begin
    logic [4:0] exp_v;
    logic [4:0] act_v;
    logic ev, eo, ed, hf;
    ev = 1'b0; eo = 1'b0; ed = 1'b0;
    for (int j = 0; j < nw; j++) begin
      if (ld[j] <= cyc && cyc < ld[j] + FL) begin
        ev = 1'b1;
        eo = fr[j][FL-1-(cyc-ld[j])];
        ed = (cyc - ld[j] == FL - 1);
      end
    end
    hf = (nw > 0) && (ld[nw-1] > cyc);
    exp_v = {eo, ev, ed, ev | hf, ~hf};
    act_v = {ser_out, ser_valid, frame_done, busy, din_ready};
    checks = checks + 1;
    if (act_v !== exp_v) begin
      failures = failures + 1;
      $display("FAIL cycle %0d {out,valid,done,busy,ready} got %b want %b",
               cyc, act_v, exp_v);
    end
  end

  bit capq[$];
  int vq[$];
  int doneq[$];
  int ncyc = 0;

  always @(negedge clk) begin
    ncyc = ncyc + 1;
    if (rst_n && ser_valid) begin
      capq.push_back(ser_out);
      vq.push_back(ncyc);
      if (frame_done) doneq.push_back(capq.size() - 1);
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks = checks + 1;
    if (act != exp) begin
      failures = failures + 1;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] bits(input int s, input int n);
    logic [31:0] r = '0;
    for (int i = 0; i < n; i++) begin
      r = {r[30:0], (s + i < capq.size()) ? capq[s+i] : 1'b0};
    end
    return r;
  endfunction

  task automatic put(input logic [7:0] w);
    int n = 0;
    logic ok = 1'b0;
    din = w;
    din_valid = 1'b1;
    while (!ok && n < 60) begin
      @(negedge clk);
      ok = din_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) begin
      failures = failures + 1;
      $display("FAIL put timeout word %0h", w);
    end
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int s, d0, lat, bad, n;
    rst_n = 1'b0;
    din = '0;
    din_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (ser_out !== 1'b0 || ser_valid !== 1'b0 ||
          din_ready !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("reset_idle_cycles_bad", bad, 0);
    @(posedge clk);
    #1;

    s = capq.size();
    d0 = doneq.size();
    put(8'h90);
    din_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ser_valid && lat < 20);
    chk("single_latency", lat, 2);
    idle(FL + 4);
    chk("single_bits", bits(s, FL), E90);
    chk("single_nbits", capq.size() - s, FL);
    chk("single_ndone", doneq.size() - d0, 1);
    if (doneq.size() > d0) chk("single_done_pos", doneq[d0], s + FL - 1);

    s = capq.size();
    put(8'hA5);
    put(8'h3C);
    din_valid = 1'b0;
    idle(2 * FL + 4);
    chk("b2b_bits", bits(s, 2 * FL), EA53C);
    chk("b2b_nbits", capq.size() - s, 2 * FL);
    if (capq.size() >= s + 2 * FL)
      chk("b2b_gapless", vq[s+2*FL-1] - vq[s], 2 * FL - 1);

    s = capq.size();
    put(8'hF0);
    put(8'h0F);
    foreach (EF00F[i]) begin
      if (i < 4) begin
        din = 8'h55 + 8'(i * 37);
        @(posedge clk);
        #1;
      end
    end
    din_valid = 1'b0;
    idle(2 * FL + 4);
    chk("bp_bits", bits(s, 2 * FL), EF00F);
    chk("bp_nbits", capq.size() - s, 2 * FL);

    s = capq.size();
    put(8'hFF);
    din_valid = 1'b0;
    n = 0;
    while (capq.size() - s < 3 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_wait_3bits", capq.size() - s, 3);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_async_outs", {ser_out, ser_valid, frame_done, busy}, 4'b0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    s = capq.size();
    put(8'h81);
    din_valid = 1'b0;
    idle(FL + 4);
    chk("post_rst_bits", bits(s, FL), E81);
    chk("post_rst_nbits", capq.size() - s, FL);

    s = capq.size();
    d0 = doneq.size();
    put(8'h07);
    din_valid = 1'b0;
    idle(FL + 4);
    chk("w07_bits", bits(s, FL), E07);
    chk("w07_ndone", doneq.size() - d0, 1);
    if (doneq.size() > d0) chk("w07_done_pos", doneq[d0], s + FL - 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pattern_serializer.md
Name: pattern_serializer

Overview:
- Parallel-to-serial stage directly upstream of the serial pattern detector.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them MSB-first, one bit per clk, on ser_out; ser_out drives the detector's serial input.
- Has a one-word holding register, so back-to-back words stream with no idle gap.
- Emits IDLE_BIT whenever no frame is active.

Parameters:
- WIDTH, 8, data bits per word; legal range is 2 and above.
- IDLE_BIT, 1'b0, value driven on ser_out while idle.
- PARITY_ODD, 0, parity sense when the parity feature is compiled in: 0 = even, 1 = odd.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- din  in  WIDTH  parallel word to serialize.
- din_valid  in  1  din holds a valid word.
- din_ready  out  1  block can accept a word; equals !hold_full.
- ser_out  out  1  registered serial bit, to the detector input.
- ser_valid  out  1  high while ser_out carries a frame bit.
- frame_done  out  1  one-cycle pulse, coincident with the last bit of a frame.
- busy  out  1  high in SHIFT or while hold_full.

Behaviour:
- Reset (async, rst_n=0):
  - state=SER_IDLE, hold_full=0, shift register=0, bit count=0.
  - ser_out=IDLE_BIT, ser_valid=0, frame_done=0, busy=0.
  - din_ready reads 1 from the first cycle after rst_n deasserts.
- Accept: a word is accepted on a posedge with din_valid && din_ready, and is written into the hold register (hold_full<=1). din is ignored when din_ready=0.
- State SER_IDLE:
  - If hold_full: load shift_reg<=hold, clear hold_full, cnt<=0, go to SER_SHIFT.
  - Otherwise ser_out=IDLE_BIT and ser_valid=0.
- State SER_SHIFT:
  - ser_out=shift_reg[WIDTH-1] and ser_valid=1.
  - Each posedge: shift left by one and cnt<=cnt+1.
  - cnt width is $clog2(WIDTH+1).
- Frame end, on the cycle where cnt==WIDTH-1 (last bit showing):
  - frame_done=1.
  - At the next edge, if hold_full: reload from hold, clear hold_full, cnt<=0, stay in SER_SHIFT. This gives a gapless stream.
  - Otherwise go to SER_IDLE.
- Latency: a word accepted at edge k loads at edge k+1. Its MSB is on ser_out during the cycle after k+1 and is sampled by the detector at edge k+2.
- Simultaneous events:
  - An accept and a hold->shift transfer on the same edge cannot collide, because din_ready=0 whenever hold_full=1.
  - A transfer and a new accept therefore land on different edges; sustained throughput is 1 word per WIDTH cycles.
- Frame boundaries: no framing markers are inserted. The bitstream is continuous across words and across idle fill, so detector matches may span words or idle bits.
- Reset mid-frame: the partial frame and any held word are discarded, and ser_out returns to IDLE_BIT immediately (async).
- All outputs except din_ready are registered; din_ready is a direct decode of hold_full.

Optional Feature:
- Macro: SERIAL_PARITY_EN.
- Defined: each frame is WIDTH+1 bits. After the data LSB, one parity bit is emitted: XOR of the word, inverted when PARITY_ODD=1. frame_done and the reload move to the parity-bit cycle, and the terminal cnt becomes WIDTH.
- Undefined: frame is WIDTH bits and no parity logic is synthesized.

Decomposition:
- Shared package pattern_pkg:
  - typedef ser_state_t {SER_IDLE, SER_SHIFT}.
  - Constant SER_DEFAULT_WIDTH=8.
  - Function for frame length, WIDTH or WIDTH+1 depending on SERIAL_PARITY_EN.
- One sub-module, ser_hold_buf: the single-entry hold register with din_ready/hold_full and a pop strobe. The shift/count FSM stays in the top level.

Test Plan:
- Reset check: rst_n=0 then 1 with din_valid=0 -> ser_out=0, ser_valid=0, din_ready=1, busy=0 for 20 cycles.
- Single word: din=8'h90 accepted at edge k -> ser_out=1,0,0,1,0,0,0,0 over cycles k+2..k+9, frame_done only on the 8th bit, then IDLE_BIT. Feeding this into the detector asserts its output after the 4th bit.
- Back-to-back: din_valid held high with 8'hA5 then 8'h3C -> 16 contiguous bits 10100101 00111100, ser_valid never drops, din_ready low from 1 cycle after the second accept until the second reload edge.
- Backpressure: din_valid=1 while hold_full=1 with din changing -> changed values never appear on ser_out; only the held word is emitted.
- Async reset mid-frame: assert rst_n=0 after 3 bits of 8'hFF -> ser_out=0 and ser_valid=0 immediately. After release, new word 8'h81 emits 10000001 cleanly.
- With SERIAL_PARITY_EN and PARITY_ODD=0: din=8'h07 -> 9 bits 00000111 then 1, with frame_done on the 9th bit.
